// File: rtl/speaker_serializer.sv
// Left-justified 4-wire audio DAC serializer: one 9-bit divider derives mclk/sck/lrck,
// 16-bit L/R samples are captured once per frame and shifted out MSB-first on sdin.
module speaker_serializer #(
  parameter logic LEFT_LRCK_LVL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
  input  logic        mute,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        sample_req
);

  logic [8:0]  cnt;
  logic [8:0]  cnt_next;
  logic [15:0] shadow_l;
  logic [15:0] shadow_r;
  logic [15:0] shadow_l_next;
  logic [15:0] shadow_r_next;
  logic        capture;
  logic        sdin_next;

  // sdin is registered from next-state values so it lines up with the current cnt
  // without a cycle of lag; the MSB therefore lands exactly on the lrck edge.
  always_comb begin
    cnt_next      = cnt + 9'd1;
    capture       = (cnt == 9'd511);
    shadow_l_next = shadow_l;
    shadow_r_next = shadow_r;
    if (capture) begin
      shadow_l_next = mute ? 16'h0000 : audio_left;
      shadow_r_next = mute ? 16'h0000 : audio_right;
    end
    sdin_next = cnt_next[8] ? shadow_r_next[~cnt_next[7:4]]
                            : shadow_l_next[~cnt_next[7:4]];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the shadow registers are plain flops, so resetting them is cheap
  // and guarantees the first frame after reset is silent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= 9'd0;
      shadow_l   <= 16'h0000;
      shadow_r   <= 16'h0000;
      audio_sdin <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      shadow_l   <= shadow_l_next;
      shadow_r   <= shadow_r_next;
      audio_sdin <= sdin_next;
      sample_req <= (cnt_next == 9'd511);
    end
  end

  // Interface clocks come straight from divider flops, so they cannot glitch.
  assign audio_mclk = cnt[1];
  assign audio_sck  = cnt[3];
  assign audio_lrck = cnt[8] ^ LEFT_LRCK_LVL;

endmodule

// File: tb/tb_speaker_serializer.sv
// Self-checking bench for speaker_serializer: directed frame scenarios followed by
// random input traffic, all compared cycle by cycle against a frame-level model.
module tb_speaker_serializer;

  logic        clk;
  logic        rst_n;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        mute;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;
  logic        sample_req;

  speaker_serializer #(.LEFT_LRCK_LVL(1'b0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .mute        (mute),
    .audio_mclk  (audio_mclk),
    .audio_lrck  (audio_lrck),
    .audio_sck   (audio_sck),
    .audio_sdin  (audio_sdin),
    .sample_req  (sample_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Frame-level model: position within the 512-clk frame and the sample pair in flight.
  int          phase    = 0;
  logic [15:0] frame_l  = 16'h0000;
  logic [15:0] frame_r  = 16'h0000;
  bit          in_reset = 1'b1;
  int          since_release = 0;
  int          req_count = 0;
  int          first_req = -1;
  logic        prev_sdin = 1'b0;
  logic [31:0] sck_bits  = 32'h0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock: advance the model on the rising edge, compare outputs on the falling edge.
  task automatic tick();
    logic [15:0] word;
    bit          exp_sdin;
    bit          changed;
    @(posedge clk);
    if (!rst_n) begin
      phase    = 0;
      frame_l  = 16'h0000;
      frame_r  = 16'h0000;
      in_reset = 1'b1;
      since_release = 0;
    end else begin
      if (phase == 511) begin
        frame_l = mute ? 16'h0000 : audio_left;
        frame_r = mute ? 16'h0000 : audio_right;
      end
      phase    = (phase + 1) % 512;
      in_reset = 1'b0;
      since_release++;
    end
    @(negedge clk);
    word     = (phase < 256) ? frame_l : frame_r;
    exp_sdin = word[15 - ((phase % 256) / 16)];
    check("mclk", {31'd0, audio_mclk}, {31'd0, 1'((phase / 2) % 2)});
    check("sck",  {31'd0, audio_sck},  {31'd0, 1'((phase / 8) % 2)});
    check("lrck", {31'd0, audio_lrck}, {31'd0, 1'(phase >= 256)});
    check("sdin", {31'd0, audio_sdin}, {31'd0, exp_sdin});
    check("sample_req", {31'd0, sample_req}, {31'd0, 1'(phase == 511 && !in_reset)});
    changed = (audio_sdin !== prev_sdin);
    check("sdin_edge_off_sck_fall", {31'd0, 1'(changed && (phase % 16) != 0 && !in_reset)}, 32'd0);
    prev_sdin = audio_sdin;
    if (sample_req === 1'b1) begin
      req_count++;
      if (first_req < 0) first_req = since_release;
    end
    if (phase % 16 == 8) sck_bits = {sck_bits[30:0], audio_sdin};
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < 600 && phase != p; i++) tick();
    check("run_to_reached", phase, p);
  endtask

  initial begin
    rst_n       = 1'b0;
    audio_left  = 16'hB000;
    audio_right = 16'h5FFF;
    mute        = 1'b0;
    repeat (3) tick();
    check("reset_lrck_level", {31'd0, audio_lrck}, 32'd0);
    check("reset_sdin", {31'd0, audio_sdin}, 32'd0);
    rst_n = 1'b1;

    // Free run 1024 clk: first frame silent, second frame carries B000/5FFF.
    run_to(511);
    check("first_frame_zero", sck_bits, 32'h0000_0000);
    run_to(0);
    run_to(511);
    check("second_frame_bits", sck_bits, 32'hB000_5FFF);
    check("req_count_1024", req_count, 2);
    check("first_req_cycle", first_req, 511);
    check("second_req_cycle", since_release, 1023);

    // Mid-frame input change does not disturb the frame in flight.
    run_to(100);
    audio_left = 16'h5FFF;
    run_to(511);
    check("midframe_old_data", sck_bits, 32'hB000_5FFF);
    run_to(0);
    run_to(511);
    check("midframe_new_data", sck_bits, 32'h5FFF_5FFF);

    // Mute across a capture silences exactly the following frame.
    audio_left  = 16'hB000;
    audio_right = 16'hB000;
    run_to(400);
    mute = 1'b1;
    run_to(50);
    mute = 1'b0;
    run_to(511);
    check("muted_frame", sck_bits, 32'h0000_0000);
    run_to(0);
    run_to(511);
    check("unmuted_frame", sck_bits, 32'hB000_B000);

    // Reset at cnt==300 held for 3 cycles, then realignment.
    run_to(300);
    req_count = 0;
    first_req = -1;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_req_quiet", req_count, 0);
    check("reset_lrck", {31'd0, audio_lrck}, 32'd0);
    rst_n = 1'b1;
    run_to(511);
    check("realign_req_cycle", first_req, 511);
    check("post_reset_frame_zero", sck_bits, 32'h0000_0000);

    // Random traffic: inputs and mute change at arbitrary points of the frame.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        audio_left  = 16'($urandom);
        audio_right = 16'($urandom);
      end
      if ($urandom_range(0, 255) == 0) mute = ~mute;
      if ($urandom_range(0, 2999) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
